prv_seq_alu: RTL and testbench

PRV_SEQ_ALU -- requirements
Module: prv_seq_alu

---
 rtl/prv_seq_alu_pkg.sv | 47 ++++
 rtl/prv_seq_alu_shifter.sv | 41 ++++
 rtl/prv_seq_alu.sv | 239 +++++++++++++++++++++++
 tb/tb_prv_seq_alu.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prv_seq_alu_pkg.sv
// ============================================================================
// prv_seq_alu_pkg : shared op codes, FSM states and operand-sign helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package prv_seq_alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_PASS = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;

  localparam logic [2:0] M_MUL    = 3'd0;
  localparam logic [2:0] M_MULH   = 3'd1;
  localparam logic [2:0] M_MULHSU = 3'd2;
  localparam logic [2:0] M_MULHU  = 3'd3;
  localparam logic [2:0] M_DIV    = 3'd4;
  localparam logic [2:0] M_DIVU   = 3'd5;
  localparam logic [2:0] M_REM    = 3'd6;
  localparam logic [2:0] M_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic m_signed_a(input logic [2:0] f3);
    return (f3 == M_MUL) || (f3 == M_MULH) || (f3 == M_MULHSU) ||
           (f3 == M_DIV) || (f3 == M_REM);
  endfunction

  function automatic logic m_signed_b(input logic [2:0] f3);
    return (f3 == M_MUL) || (f3 == M_MULH) || (f3 == M_DIV) || (f3 == M_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/prv_seq_alu_shifter.sv
// ============================================================================
// prv_shifter_p : log-stage barrel shifter (SRL / SRA / SLL)
// Rev 1.0
// ============================================================================
`default_nettype none

module prv_shifter_p #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [SHW-1:0]  shamt_i,
  input  logic            left_i,
  input  logic            arith_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] src;
  logic [XLEN-1:0] res;
  logic            fill;

  // Left shifts reuse the right-shift stages on a bit-reversed operand.
  for (genvar i = 0; i < XLEN; i++) begin : g_rev
    assign src[i]    = left_i ? data_i[XLEN-1-i] : data_i[i];
    assign data_o[i] = left_i ? res[XLEN-1-i]    : res[i];
  end

  assign fill = arith_i & ~left_i & data_i[XLEN-1];

  always_comb begin
    res = src;
    for (int k = 0; k < SHW; k++) begin
      if (shamt_i[k]) begin
        res = (res >> (1 << k)) | (fill ? ~({XLEN{1'b1}} >> (1 << k)) : '0);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/prv_seq_alu.sv
// ============================================================================
// prv_seq_alu : single-cycle base ALU plus iterative RV M-extension mul/div
// Rev 1.0
// ============================================================================
`default_nettype none

module prv_seq_alu
  import prv_seq_alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alufn,
  input  logic            m_en,
  input  logic [2:0]      m_funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] r,
  output logic            cf,
  output logic            zf,
  output logic            vf,
  output logic            sf
);

  localparam int              CW       = SHW + 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [XLEN-1:0] r_q, r_d;
  logic            cf_q, cf_d, zf_q, zf_d, vf_q, vf_d, sf_q, sf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d;

  // Base ALU: one adder shared by ADD and every subtract-type op.
  logic            sub_mode;
  logic [XLEN-1:0] b_op, sum, sh_res, base_res;
  logic [XLEN:0]   sum_ext;
  logic            add_c, add_z, add_v, add_s;

  assign sub_mode = (alufn != ALU_ADD);
  assign b_op     = sub_mode ? ~b : b;
  assign sum_ext  = {1'b0, a} + {1'b0, b_op} + {{XLEN{1'b0}}, sub_mode};
  assign sum      = sum_ext[XLEN-1:0];
  assign add_c    = sum_ext[XLEN];
  assign add_z    = (sum == '0);
  assign add_s    = sum[XLEN-1];
  assign add_v    = (a[XLEN-1] == b_op[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);

  prv_shifter_p #(.XLEN(XLEN), .SHW(SHW)) u_shifter (
    .data_i  (a),
    .shamt_i (b[SHW-1:0]),
    .left_i  (alufn == ALU_SLL),
    .arith_i (alufn == ALU_SRA),
    .data_o  (sh_res)
  );

  always_comb begin
    base_res = '0;
    case (alufn)
      ALU_ADD, ALU_SUB: base_res = sum;
      ALU_PASS:         base_res = b;
      ALU_OR:           base_res = a | b;
      ALU_AND:          base_res = a & b;
      ALU_XOR:          base_res = a ^ b;
      ALU_SRL, ALU_SRA, ALU_SLL: base_res = sh_res;
      ALU_SLT:          base_res = {{(XLEN-1){1'b0}}, add_s ^ add_v};
      ALU_SLTU:         base_res = {{(XLEN-1){1'b0}}, ~add_c};
      default:          base_res = '0;
    endcase
  end

  // M-op setup: the iterative core works on magnitudes only.
  logic            a_neg, b_neg, is_div, div_zero, div_ovf, m_bypass;
  logic [XLEN-1:0] a_mag, b_mag, bypass_res;

  assign a_neg    = m_signed_a(m_funct3) & a[XLEN-1];
  assign b_neg    = m_signed_b(m_funct3) & b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign is_div   = m_funct3[2];
  assign div_zero = (b == '0);
  assign div_ovf  = ((m_funct3 == M_DIV) || (m_funct3 == M_REM)) &&
                    (a == SMIN) && (b == '1);
  assign m_bypass = is_div && (div_zero || div_ovf);

  always_comb begin
    if (div_zero) bypass_res = m_funct3[1] ? a : '1;
    else          bypass_res = m_funct3[1] ? '0 : a;
  end

  // One shift-add or restoring-divide step; hi holds product-high / remainder.
  logic [XLEN:0]     madd, rem_sh;
  logic [XLEN-1:0]   dsub, hi_n, lo_n, m_res;
  logic [2*XLEN-1:0] prod;
  logic              dge;

  assign madd   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
  assign rem_sh = {hi_q, lo_q[XLEN-1]};
  assign dge    = (rem_sh >= {1'b0, opnd_q});
  assign dsub   = rem_sh[XLEN-1:0] - opnd_q;

  always_comb begin
    if (op_q[2]) begin
      hi_n = dge ? dsub : rem_sh[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], dge};
    end else begin
      hi_n = madd[XLEN:1];
      lo_n = {madd[0], lo_q[XLEN-1:1]};
    end
  end

  assign prod = qneg_q ? -{hi_n, lo_n} : {hi_n, lo_n};

  always_comb begin
    m_res = '0;
    case (op_q)
      M_MUL:                     m_res = prod[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU: m_res = prod[2*XLEN-1:XLEN];
      M_DIV, M_DIVU:             m_res = qneg_q ? -lo_n : lo_n;
      default:                   m_res = rneg_q ? -hi_n : hi_n;
    endcase
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cf_d    = cf_q;
    zf_d    = zf_q;
    vf_d    = vf_q;
    sf_d    = sf_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!m_en) begin
            state_d = DONE;
            r_d     = base_res;
            cf_d    = add_c;
            zf_d    = add_z;
            vf_d    = add_v;
            sf_d    = add_s;
          end else if (m_bypass) begin
            state_d = DONE;
            r_d     = bypass_res;
            cf_d    = 1'b0;
            zf_d    = (bypass_res == '0);
            vf_d    = 1'b0;
            sf_d    = 1'b0;
          end else begin
            state_d = CALC;
            cnt_d   = CNT_LOAD;
            op_d    = m_funct3;
            hi_d    = '0;
            lo_d    = is_div ? a_mag : b_mag;
            opnd_d  = is_div ? b_mag : a_mag;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q - 1'b1;
        hi_d  = hi_n;
        lo_d  = lo_n;
        // Last step and sign fix-up share one cycle.
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          r_d     = m_res;
          cf_d    = 1'b0;
          zf_d    = (m_res == '0);
          vf_d    = 1'b0;
          sf_d    = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
      vf_q    <= 1'b0;
      sf_q    <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cf_q    <= cf_d;
      zf_q    <= zf_d;
      vf_q    <= vf_d;
      sf_q    <= sf_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign r         = r_q;
  assign cf        = cf_q;
  assign zf        = zf_q;
  assign vf        = vf_q;
  assign sf        = sf_q;

endmodule

`default_nettype wire

// File: tb/tb_prv_seq_alu.sv
// ============================================================================
// tb_prv_seq_alu : directed + random stimulus against an arithmetic model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_prv_seq_alu;
  import prv_seq_alu_pkg::*;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  alufn = '0;
  logic        m_en = 1'b0;
  logic [2:0]  m_funct3 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] r;
  logic        cf, zf, vf, sf;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          rst_prev = 1'b0;
  bit          busy = 1'b0;
  int          due = 0;
  logic [35:0] exp_v = '0;

  prv_seq_alu #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alufn     (alufn),
    .m_en      (m_en),
    .m_funct3  (m_funct3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .cf        (cf),
    .zf        (zf),
    .vf        (vf),
    .sf        (sf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    rst_prev = rst;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Result as {cf,zf,vf,sf,r} computed from plain integer arithmetic.
  function automatic logic [35:0] model(input logic [3:0] fn, input logic men,
                                        input logic [2:0] f3, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [31:0] res;
    logic        c, z, v, s;
    longint      sx, sy, wide;
    logic [63:0] uw;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = '0; c = 1'b0; v = 1'b0; s = 1'b0; wide = 0; uw = '0;
    if (men) begin
      case (f3)
        M_MUL:    begin wide = sx * sy; res = wide[31:0]; end
        M_MULH:   begin wide = sx * sy; res = wide[63:32]; end
        M_MULHSU: begin wide = sx * longint'({32'b0, y}); res = wide[63:32]; end
        M_MULHU:  begin uw = {32'b0, x} * {32'b0, y}; res = uw[63:32]; end
        M_DIV: begin
          if (y == 0) res = 32'hFFFF_FFFF;
          else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) res = x;
          else begin wide = sx / sy; res = wide[31:0]; end
        end
        M_REM: begin
          if (y == 0) res = x;
          else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) res = 0;
          else begin wide = sx % sy; res = wide[31:0]; end
        end
        M_DIVU:  res = (y == 0) ? 32'hFFFF_FFFF : x / y;
        default: res = (y == 0) ? x : x % y;
      endcase
      z = (res == 0);
    end else begin
      if (fn == ALU_ADD) begin
        wide = sx + sy;
        uw   = {32'b0, x} + {32'b0, y};
        c    = uw[32];
      end else begin
        wide = sx - sy;
        c    = (x >= y);
      end
      v = (wide > SMAX) || (wide < SMIN);
      s = wide[31];
      z = (wide[31:0] == 0);
      case (fn)
        ALU_ADD, ALU_SUB: res = wide[31:0];
        ALU_PASS: res = y;
        ALU_OR:   res = x | y;
        ALU_AND:  res = x & y;
        ALU_XOR:  res = x ^ y;
        ALU_SRL:  res = x >> y[4:0];
        ALU_SRA:  res = $signed(x) >>> y[4:0];
        ALU_SLL:  res = x << y[4:0];
        ALU_SLT:  res = {31'b0, sx < sy};
        ALU_SLTU: res = {31'b0, x < y};
        default:  res = '0;
      endcase
    end
    return {c, z, v, s, res};
  endfunction

  function automatic int model_lat(input logic men, input logic [2:0] f3,
                                   input logic [31:0] x, input logic [31:0] y);
    if (!men) return 1;
    if (f3[2] && y == 0) return 1;
    if ((f3 == M_DIV || f3 == M_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Single checker: every cycle, outputs are compared with what the model says.
  always @(negedge clk) begin
    if (rst_prev) begin
      chk("reset_out_valid", out_valid, 0);
      chk("reset_r", r, 0);
      chk("reset_flags", {cf, zf, vf, sf}, 0);
      chk("reset_in_ready", in_ready, 1);
    end else if (!rst) begin
      if (!busy) begin
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);
      end else if (cyc < due) begin
        chk("busy_out_valid", out_valid, 0);
        chk("busy_in_ready", in_ready, 0);
      end else begin
        chk("done_out_valid", out_valid, 1);
        chk("done_in_ready", in_ready, 0);
        chk("result_r", r, exp_v[31:0]);
        chk("result_flags_czvs", {cf, zf, vf, sf}, exp_v[35:32]);
      end
    end
  end

  task automatic scramble();
    in_valid = 1'($urandom_range(0, 1));
    a        = $urandom;
    b        = $urandom;
    alufn    = 4'($urandom_range(0, 15));
    m_en     = 1'($urandom_range(0, 1));
    m_funct3 = 3'($urandom_range(0, 7));
  endtask

  task automatic do_accept(input logic [3:0] fn, input logic men, input logic [2:0] f3,
                           input logic [31:0] x, input logic [31:0] y, output bit ok);
    int waitc;
    a = x; b = y; alufn = fn; m_en = men; m_funct3 = f3;
    in_valid = 1'b1;
    waitc = 0;
    @(negedge clk);
    while (!in_ready && waitc < 100) begin
      waitc++;
      @(negedge clk);
    end
    ok = in_ready;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1 within 100 cycles");
      in_valid = 1'b0;
    end else begin
      exp_v = model(fn, men, f3, x, y);
      due   = cyc + model_lat(men, f3, x, y);
      @(posedge clk);
      #1;
      busy = 1'b1;
      scramble();
    end
  endtask

  task automatic do_finish(input int stall);
    while (cyc < due) begin
      @(posedge clk);
      #1;
      scramble();
    end
    repeat (stall) begin
      @(posedge clk);
      #1;
      scramble();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    busy      = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] fn, input logic men, input logic [2:0] f3,
                        input logic [31:0] x, input logic [31:0] y, input int stall);
    bit ok;
    do_accept(fn, men, f3, x, y, ok);
    if (ok) do_finish(stall);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit ok;
    // Hand-computed anchors for the model.
    chk("pin_add_ovf",   model(ALU_ADD, 0, M_MUL, 32'h7FFF_FFFF, 32'd1), {4'b0011, 32'h8000_0000});
    chk("pin_mul",       model(ALU_ADD, 1, M_MUL, 32'hFFFF_FFFD, 32'd7), {4'b0000, 32'hFFFF_FFEB});
    chk("pin_mulh",      model(ALU_ADD, 1, M_MULH, 32'hFFFF_FFFD, 32'd7), {4'b0000, 32'hFFFF_FFFF});
    chk("pin_mulhu",     model(ALU_ADD, 1, M_MULHU, 32'hFFFF_FFFD, 32'd7), {4'b0000, 32'h0000_0006});
    chk("pin_div0",      model(ALU_ADD, 1, M_DIV, 32'd5, 32'd0), {4'b0000, 32'hFFFF_FFFF});
    chk("pin_rem0",      model(ALU_ADD, 1, M_REM, 32'd5, 32'd0), {4'b0000, 32'd5});
    chk("pin_div_ovf",   model(ALU_ADD, 1, M_DIV, 32'h8000_0000, 32'hFFFF_FFFF), {4'b0000, 32'h8000_0000});
    chk("pin_rem_ovf",   model(ALU_ADD, 1, M_REM, 32'h8000_0000, 32'hFFFF_FFFF), {4'b0100, 32'h0});
    chk("pin_div_neg",   model(ALU_ADD, 1, M_DIV, 32'hFFFF_FFF9, 32'd2), {4'b0000, 32'hFFFF_FFFD});
    chk("pin_rem_neg",   model(ALU_ADD, 1, M_REM, 32'hFFFF_FFF9, 32'd2), {4'b0000, 32'hFFFF_FFFF});
    chk("pin_divu",      model(ALU_ADD, 1, M_DIVU, 32'd100, 32'd7), {4'b0000, 32'd14});
    chk("pin_add_small", model(ALU_ADD, 0, M_MUL, 32'd2, 32'd3), {4'b0000, 32'd5});
    chk("pin_lat_mul",   32'(model_lat(1, M_MUL, 32'd3, 32'd7)), 33);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_op(ALU_ADD, 0, M_MUL, 32'h7FFF_FFFF, 32'd1, 0);
    run_op(ALU_ADD, 1, M_MUL, 32'hFFFF_FFFD, 32'd7, 0);
    run_op(ALU_ADD, 1, M_MULH, 32'hFFFF_FFFD, 32'd7, 1);
    run_op(ALU_ADD, 1, M_MULHU, 32'hFFFF_FFFD, 32'd7, 0);
    run_op(ALU_ADD, 1, M_MULHSU, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    run_op(ALU_ADD, 1, M_DIV, 32'd5, 32'd0, 0);
    run_op(ALU_ADD, 1, M_REM, 32'd5, 32'd0, 0);
    run_op(ALU_ADD, 1, M_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(ALU_ADD, 1, M_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(ALU_ADD, 1, M_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(ALU_ADD, 1, M_REM, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(ALU_ADD, 1, M_DIVU, 32'd100, 32'd7, 0);
    run_op(ALU_SRA, 0, M_MUL, 32'h8000_00F0, 32'hFFFF_FFE4, 0);
    run_op(ALU_SLL, 0, M_MUL, 32'h0000_0003, 32'h0000_003F, 0);
    run_op(ALU_SLT, 0, M_MUL, 32'h8000_0000, 32'h0000_0001, 0);
    run_op(ALU_SUB, 0, M_MUL, 32'd10, 32'd3, 5);

    // Reset in the middle of a multiply: nothing may come out afterwards.
    do_accept(ALU_ADD, 1, M_MUL, 32'hFFFF_FFFD, 32'd7, ok);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    rst  = 1'b1;
    busy = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    run_op(ALU_ADD, 0, M_MUL, 32'd2, 32'd3, 0);

    for (int n = 0; n < 150; n++) begin
      run_op(4'($urandom_range(0, 10)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             rnd_opnd(), rnd_opnd(), int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
